// File: rtl/wb_spi_slave_if.sv
// Wishbone slave bus (8-bit data, registered-feedback acks) shared by the host
// and the wb_spi_slave peripheral.
interface wb_spi_slave_if;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       we_i;
  logic       stb_i;
  logic       ack_o;

  modport master (output dat_i, we_i, stb_i, input dat_o, ack_o);
  modport slave  (input dat_i, we_i, stb_i, output dat_o, ack_o);
endinterface

// File: rtl/fifo.sv
// Synchronous byte queue with first-word-fall-through head, registered occupancy
// and a flush that overrides any coincident push or pop.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rstz,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] size
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush, doPop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_COUNT);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr_q];
  assign size   = count_q;

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= din;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/spi_slave.sv
// SPI slave PHY: oversamples sclk/cs_n/mosi in the clk domain and shifts one byte
// per 8 sample edges in any CPOL/CPHA mode, MSB first.
module spi_slave (
  input  logic       clk,
  input  logic       rstz,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       cpol,
  input  logic       cpha,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic [7:0] dout,
  output logic       dout_vld
);
  enum logic {IDLE, ACTIVE} state_q, state_d;

  logic [1:0] sclkSync_q, csSync_q, mosiSync_q;
  logic       sclkPrev_q, csPrev_q, mosiDly_q;
  logic [2:0] bitCnt_q;
  logic [7:0] txShift_q, rxShift_q, dout_q;
  logic       doutVld_q;
  logic       sclkRise, sclkFall, csFall, csRise;
  logic       leadEdge, trailEdge, sampleEdge, shiftEdge;
  logic       doSample, doShift;

  assign sclkRise   = sclkSync_q[1] & ~sclkPrev_q;
  assign sclkFall   = ~sclkSync_q[1] & sclkPrev_q;
  assign csFall     = ~csSync_q[1] & csPrev_q;
  assign csRise     = csSync_q[1] & ~csPrev_q;
  assign leadEdge   = cpol ? sclkFall : sclkRise;
  assign trailEdge  = cpol ? sclkRise : sclkFall;
  assign sampleEdge = cpha ? trailEdge : leadEdge;
  assign shiftEdge  = cpha ? leadEdge : trailEdge;
  assign dout       = dout_q;
  assign dout_vld   = doutVld_q;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && csFall)        state_d = ACTIVE;
    else if (state_q == ACTIVE && csRise) state_d = IDLE;
  end

  // The shift edge at bitCnt 0 is skipped so the freshly loaded MSB stays on miso.
  always_comb begin
    miso_oe  = (state_q == ACTIVE);
    miso     = (state_q == ACTIVE) ? txShift_q[7] : 1'b0;
    din_rdy  = 1'b0;
    doSample = 1'b0;
    doShift  = 1'b0;
    if (state_q == IDLE) begin
      din_rdy = csFall;
    end else if (!csRise) begin
      doSample = sampleEdge;
      doShift  = shiftEdge && (bitCnt_q != 3'd0);
      din_rdy  = sampleEdge && (bitCnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      sclkSync_q <= 2'b00;
      csSync_q   <= 2'b11;
      mosiSync_q <= 2'b00;
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b1;
      mosiDly_q  <= 1'b0;
      bitCnt_q   <= 3'd0;
      txShift_q  <= 8'h00;
      rxShift_q  <= 8'h00;
      dout_q     <= 8'h00;
      doutVld_q  <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[0], sclk};
      csSync_q   <= {csSync_q[0], cs_n};
      mosiSync_q <= {mosiSync_q[0], mosi};
      sclkPrev_q <= sclkSync_q[1];
      csPrev_q   <= csSync_q[1];
      mosiDly_q  <= mosiSync_q[1];
      doutVld_q  <= 1'b0;
      if (din_rdy)      txShift_q <= din_vld ? din : 8'h00;
      else if (doShift) txShift_q <= {txShift_q[6:0], 1'b0};
      if (state_q == IDLE) begin
        bitCnt_q <= 3'd0;
      end else if (doSample) begin
        rxShift_q <= {rxShift_q[6:0], mosiDly_q};
        bitCnt_q  <= bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) begin
          dout_q    <= {rxShift_q[6:0], mosiDly_q};
          doutVld_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/wb_spi_slave.sv
// Wishbone-fronted SPI slave: host preloads TX bytes and drains RX bytes through
// two queues around the spi_slave PHY.
module wb_spi_slave #(
  parameter int BUFFER = 32
) (
  input  logic          clk,
  input  logic          rstz,
  wb_spi_slave_if.slave wb,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          tx_clear,
  input  logic          rx_clear,
  output logic [15:0]   tx_size,
  output logic [15:0]   rx_size,
  output logic          rx_overrun
);
  localparam int CW = $clog2(BUFFER) + 1;

  logic          wrAck_q, rdAck_q, rxOverrun_q;
  logic          txPush, txPop, txEmpty, txFull;
  logic          rxPop, rxEmpty, rxFull;
  logic [7:0]    txHead, rxHead, phyDout;
  logic          phyDinRdy, phyDoutVld;
  logic [CW-1:0] txCount, rxCount;

  // Registered-feedback acks: a held strobe is acked every cycle after the first.
  assign wb.ack_o   = wb.stb_i & (wrAck_q | rdAck_q);
  assign txPush     = wb.stb_i & wb.we_i & wrAck_q & ~txFull;
  assign rxPop      = wb.stb_i & ~wb.we_i & rdAck_q & ~rxEmpty;
  assign wb.dat_o   = rxEmpty ? 8'h00 : rxHead;
  assign txPop      = phyDinRdy & ~txEmpty;
  assign tx_size    = 16'(txCount);
  assign rx_size    = 16'(rxCount);
  assign rx_overrun = rxOverrun_q;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wrAck_q     <= 1'b0;
      rdAck_q     <= 1'b0;
      rxOverrun_q <= 1'b0;
    end else begin
      wrAck_q <= wb.stb_i & wb.we_i;
      rdAck_q <= wb.stb_i & ~wb.we_i;
      if (rx_clear)                  rxOverrun_q <= 1'b0;
      else if (phyDoutVld && rxFull) rxOverrun_q <= 1'b1;
    end
  end

  fifo #(.WIDTH(8), .DEPTH(BUFFER)) u_txq (
    .clk(clk), .rstz(rstz), .clear(tx_clear),
    .push(txPush), .din(wb.dat_i), .pop(txPop), .dout(txHead),
    .empty(txEmpty), .full(txFull), .size(txCount)
  );

  fifo #(.WIDTH(8), .DEPTH(BUFFER)) u_rxq (
    .clk(clk), .rstz(rstz), .clear(rx_clear),
    .push(phyDoutVld), .din(phyDout), .pop(rxPop), .dout(rxHead),
    .empty(rxEmpty), .full(rxFull), .size(rxCount)
  );

  spi_slave u_phy (
    .clk(clk), .rstz(rstz), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .cpol(cpol), .cpha(cpha), .miso(miso), .miso_oe(miso_oe),
    .din(txHead), .din_vld(~txEmpty), .din_rdy(phyDinRdy),
    .dout(phyDout), .dout_vld(phyDoutVld)
  );
endmodule

// File: tb/tb_wb_spi_slave.sv
// Directed bench for wb_spi_slave: a behavioural SPI master and Wishbone host
// exercise all modes, multi-byte frames, overrun, aborted frames and reset.
module tb_wb_spi_slave;
  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        cpol = 1'b0, cpha = 1'b0;
  logic        txClear = 1'b0, rxClear = 1'b0;
  logic        miso, misoOe, rxOverrun;
  logic [15:0] txSize, rxSize;
  int          compareCount = 0;
  int          mismatchCount = 0;

  wb_spi_slave_if wbBus();

  always #5 clk = ~clk;

  wb_spi_slave #(.BUFFER(32)) dut (
    .clk(clk), .rstz(rstz), .wb(wbBus),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(misoOe),
    .cpol(cpol), .cpha(cpha), .tx_clear(txClear), .rx_clear(rxClear),
    .tx_size(txSize), .rx_size(rxSize), .rx_overrun(rxOverrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wbWrite(input logic [7:0] data);
    int waited = 0;
    @(posedge clk); #1;
    wbBus.stb_i = 1'b1; wbBus.we_i = 1'b1; wbBus.dat_i = data;
    @(negedge clk);
    while (!wbBus.ack_o && waited < 8) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("wb write ack", {31'd0, wbBus.ack_o}, 1);
    @(posedge clk); #1;
    wbBus.stb_i = 1'b0; wbBus.we_i = 1'b0;
  endtask

  task automatic wbRead(output logic [7:0] data, output int latency);
    latency = 0;
    @(posedge clk); #1;
    wbBus.stb_i = 1'b1; wbBus.we_i = 1'b0;
    @(negedge clk);
    while (!wbBus.ack_o && latency < 8) begin
      latency++;
      @(negedge clk);
    end
    data = wbBus.dat_o;
    checkOutput("wb read ack", {31'd0, wbBus.ack_o}, 1);
    @(posedge clk); #1;
    wbBus.stb_i = 1'b0;
  endtask

  task automatic setMode(input logic p, input logic h);
    cpol = p; cpha = h; sclk = p;
    repeat (10) @(posedge clk);
    #2;
  endtask

  task automatic spiSelect();
    cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic spiDeselect();
    #(HALF);
    cs_n = 1'b1;
    #(4 * HALF);
  endtask

  // Master side: drives mosi on its shift edge and samples miso on its sample edge.
  task automatic spiXfer(input logic [7:0] txByte, input int nbits, output logic [7:0] rxByte);
    rxByte = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = txByte[i];
        #(HALF); sclk = ~cpol; rxByte[i] = miso;
        #(HALF); sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = txByte[i];
        #(HALF); sclk = cpol; rxByte[i] = miso;
        #(HALF);
      end
    end
  endtask

  initial begin
    #(2_000_000);
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rxByte, rdByte;
    logic [7:0] frameRx [3];
    int         latency;

    wbBus.stb_i = 1'b0; wbBus.we_i = 1'b0; wbBus.dat_i = 8'h00;
    repeat (4) @(posedge clk); #2;
    checkOutput("reset miso", {31'd0, miso}, 0);
    checkOutput("reset miso_oe", {31'd0, misoOe}, 0);
    checkOutput("reset ack_o", {31'd0, wbBus.ack_o}, 0);
    checkOutput("reset rx_overrun", {31'd0, rxOverrun}, 0);
    checkOutput("reset tx_size", {16'd0, txSize}, 0);
    checkOutput("reset rx_size", {16'd0, rxSize}, 0);
    rstz = 1'b1;
    $display("[TB] reset released");

    // Mode 0 basic exchange
    setMode(1'b0, 1'b0);
    wbWrite(8'hA5);
    checkOutput("m0 tx_size after write", {16'd0, txSize}, 1);
    spiSelect();
    checkOutput("m0 miso_oe selected", {31'd0, misoOe}, 1);
    spiXfer(8'h3C, 8, rxByte);
    spiDeselect();
    checkOutput("m0 miso_oe deselected", {31'd0, misoOe}, 0);
    checkOutput("m0 master rx", {24'd0, rxByte}, 32'hA5);
    checkOutput("m0 rx_size", {16'd0, rxSize}, 1);
    checkOutput("m0 tx_size", {16'd0, txSize}, 0);
    wbRead(rdByte, latency);
    checkOutput("m0 wb read data", {24'd0, rdByte}, 32'h3C);
    checkOutput("m0 ack latency", latency, 1);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      setMode(m[1], m[0]);
      wbWrite(8'h81);
      spiSelect();
      checkOutput($sformatf("mode%0d miso_oe selected", m), {31'd0, misoOe}, 1);
      spiXfer(8'h7E, 8, rxByte);
      spiDeselect();
      checkOutput($sformatf("mode%0d miso_oe deselected", m), {31'd0, misoOe}, 0);
      checkOutput($sformatf("mode%0d master rx", m), {24'd0, rxByte}, 32'h81);
      checkOutput($sformatf("mode%0d rx_size", m), {16'd0, rxSize}, 1);
      wbRead(rdByte, latency);
      checkOutput($sformatf("mode%0d wb read data", m), {24'd0, rdByte}, 32'h7E);
    end

    // Three-byte frame with two preloaded TX bytes
    setMode(1'b0, 1'b0);
    wbWrite(8'h11);
    wbWrite(8'h22);
    spiSelect();
    spiXfer(8'hAA, 8, frameRx[0]);
    spiXfer(8'hBB, 8, frameRx[1]);
    spiXfer(8'hCC, 8, frameRx[2]);
    spiDeselect();
    checkOutput("frame master rx0", {24'd0, frameRx[0]}, 32'h11);
    checkOutput("frame master rx1", {24'd0, frameRx[1]}, 32'h22);
    checkOutput("frame master rx2", {24'd0, frameRx[2]}, 32'h00);
    checkOutput("frame rx_size", {16'd0, rxSize}, 3);
    wbRead(rdByte, latency);
    checkOutput("frame wb read0", {24'd0, rdByte}, 32'hAA);
    wbRead(rdByte, latency);
    checkOutput("frame wb read1", {24'd0, rdByte}, 32'hBB);
    wbRead(rdByte, latency);
    checkOutput("frame wb read2", {24'd0, rdByte}, 32'hCC);

    // RX overrun: 33 bytes into a 32-deep queue
    spiSelect();
    for (int i = 0; i < 33; i++) spiXfer(8'(8'h40 + i), 8, rxByte);
    spiDeselect();
    checkOutput("ovr rx_size full", {16'd0, rxSize}, 32);
    checkOutput("ovr rx_overrun set", {31'd0, rxOverrun}, 1);
    for (int i = 0; i < 32; i++) begin
      wbRead(rdByte, latency);
      checkOutput($sformatf("ovr read %0d", i), {24'd0, rdByte}, 32'h40 + i);
    end
    wbRead(rdByte, latency);
    checkOutput("ovr empty read", {24'd0, rdByte}, 32'h00);
    checkOutput("ovr rx_size drained", {16'd0, rxSize}, 0);
    checkOutput("ovr rx_overrun sticky", {31'd0, rxOverrun}, 1);
    spiSelect();
    spiXfer(8'h99, 8, rxByte);
    spiDeselect();
    checkOutput("ovr rx_size refill", {16'd0, rxSize}, 1);
    @(posedge clk); #1; rxClear = 1'b1;
    @(posedge clk); #1; rxClear = 1'b0;
    checkOutput("clr rx_size", {16'd0, rxSize}, 0);
    checkOutput("clr rx_overrun", {31'd0, rxOverrun}, 0);

    // Aborted partial frame, then a full frame
    wbWrite(8'hD4);
    wbWrite(8'h6B);
    spiSelect();
    spiXfer(8'hFF, 5, rxByte);
    spiDeselect();
    checkOutput("abort rx_size", {16'd0, rxSize}, 0);
    checkOutput("abort tx_size", {16'd0, txSize}, 1);
    spiSelect();
    spiXfer(8'hC3, 8, rxByte);
    spiDeselect();
    checkOutput("abort master rx", {24'd0, rxByte}, 32'h6B);
    checkOutput("abort rx_size after", {16'd0, rxSize}, 1);
    wbRead(rdByte, latency);
    checkOutput("abort wb read", {24'd0, rdByte}, 32'hC3);

    // Reset in the middle of a frame
    wbWrite(8'h77);
    wbWrite(8'h88);
    spiSelect();
    spiXfer(8'hFF, 4, rxByte);
    checkOutput("pre-reset tx_size", {16'd0, txSize}, 1);
    rstz = 1'b0;
    repeat (3) @(posedge clk); #2;
    checkOutput("midrst miso", {31'd0, miso}, 0);
    checkOutput("midrst miso_oe", {31'd0, misoOe}, 0);
    checkOutput("midrst ack_o", {31'd0, wbBus.ack_o}, 0);
    checkOutput("midrst rx_overrun", {31'd0, rxOverrun}, 0);
    checkOutput("midrst tx_size", {16'd0, txSize}, 0);
    checkOutput("midrst rx_size", {16'd0, rxSize}, 0);
    cs_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    rstz = 1'b1;
    setMode(1'b0, 1'b0);
    spiSelect();
    spiXfer(8'h5A, 8, rxByte);
    spiDeselect();
    checkOutput("postrst master rx", {24'd0, rxByte}, 32'h00);
    checkOutput("postrst rx_size", {16'd0, rxSize}, 1);
    wbRead(rdByte, latency);
    checkOutput("postrst wb read", {24'd0, rdByte}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule

// File: doc/wb_spi_slave.md
Name: wb_spi_slave

Overview:
8-bit full-duplex SPI slave with RX/TX byte queues behind a Wishbone slave port (8b data bus). It is the peripheral end of the SPI link: an external master drives sclk, cs_n and mosi, and this block returns miso from the TX queue. The host preloads response bytes into the TX queue and drains received bytes from the RX queue. SPI inputs are oversampled in the clk domain. All four CPOL/CPHA modes are supported.

Parameters:
BUFFER, 32, depth in bytes of each of the TX and RX queues; power of 2, 2..32768.

Ports:
clk  in  1  system clock
rstz  in  1  reset; asynchronous, active-low
sclk  in  1  SPI clock from master (async)
cs_n  in  1  chip select, active-low (async)
mosi  in  1  serial data from master (async)
miso  out  1  serial data to master
miso_oe  out  1  miso output enable; high while selected
cpol  in  1  clock polarity
cpha  in  1  clock phase
tx_clear  in  1  sync flush of TX queue
rx_clear  in  1  sync flush of RX queue; also clears rx_overrun
tx_size  out  16  TX queue occupancy, zero-extended
rx_size  out  16  RX queue occupancy, zero-extended
rx_overrun  out  1  sticky: a received byte was dropped because RX was full
dat_i  in  8  Wishbone write data
dat_o  out  8  Wishbone read data (RX queue head)
we_i  in  1  Wishbone write enable
stb_i  in  1  Wishbone strobe (cyc folded in)
ack_o  out  1  Wishbone acknowledge

Behaviour:
- Reset values: miso=0, miso_oe=0, ack_o=0, rx_overrun=0, tx_size=0, rx_size=0, both queues empty, PHY in IDLE.
- Wishbone uses registered feedback, advanced/burst:
  - wr_ack <= stb_i&we_i; rd_ack <= stb_i&~we_i.
  - ack_o = stb_i&(wr_ack|rd_ack). Back-to-back strobes ack every cycle after the first.
  - Write push on stb_i&we_i&wr_ack. If TX is full, the byte is dropped silently; still acked.
  - Read pop on stb_i&~we_i&rd_ack. dat_o = RX head; reads 0x00 when RX is empty, with no pop.
- Input sync: sclk, cs_n and mosi each pass a 2-FF synchronizer, then a 1-cycle edge register.
  - Requirement: sclk high and low phases are each at least 4 clk cycles; cs_n setup before the first edge is at least 4 clk cycles.
- Edge classification:
  - Leading edge = rising if cpol=0, falling if cpol=1.
  - Sample edge = leading if cpha=0, else trailing. Shift edge = the other edge.
- PHY FSM, states IDLE and ACTIVE:
  - IDLE->ACTIVE on synced cs_n falling. Entering ACTIVE: bit_cnt=0 and load TX shift register.
  - ACTIVE->IDLE on synced cs_n rising; has priority over any coincident sclk edge.
  - Partial byte (bit_cnt≠0) is discarded, not pushed to RX. The popped TX byte is lost, not re-queued.
- TX load: pop TX head if non-empty, else load 0x00 (no pop).
  - Occurs at select (entry to ACTIVE) and again after every 8th sample while cs_n stays low.
- miso is MSB-first:
  - cpha=0: MSB presented on the load cycle; each shift edge advances one bit.
  - cpha=1: MSB presented on the first leading (shift) edge.
  - miso_oe = ACTIVE; miso=0 in IDLE.
- RX sampling: each sample edge shifts synced mosi into rx_shift LSB; bit_cnt increments mod 8.
  - On the 8th sample, the full byte is pushed to RX the next cycle.
  - If RX is full: byte dropped, rx_overrun <= 1.
  - rx_clear clears rx_overrun; rx_clear wins when coincident with a drop.
- tx_clear/rx_clear coincident with a push or pop: the clear wins and the queue is empty the next cycle.
- cpol/cpha changes are only legal while cs_n is high.
- Size outputs come registered from the fifos.

Decomposition:
- No shared package; no new typedefs. BUFFER width math is done locally with $clog2.
- Queues reuse the existing fifo module: two instances, u_txq and u_rxq.
- One sub-module, spi_slave: synchronizers, FSM, shift registers, bit counter.
  - Its interface is din/din_vld/din_rdy (TX byte in) and dout/dout_vld (RX byte out), mirroring the existing spi_master.
- wb_spi_slave holds only the Wishbone ack logic, the queues, rx_overrun and size extension.

Test Plan:
- Mode 0, clk:sclk=10: WB write 0xA5; master clocks 0x3C -> master receives 0xA5, rx_size=1, tx_size=0; WB read returns 0x3C with ack_o one cycle after stb_i.
- Repeat for modes 1, 2, 3 with TX 0x81 and master data 0x7E -> exact byte match both directions in each mode; miso_oe high only while cs_n is low.
- TX preloaded 0x11,0x22; a 3-byte frame under one cs_n -> master receives 0x11,0x22,0x00; RX holds all 3 master bytes in order.
- Fill RX with BUFFER=32 bytes, send a 33rd -> rx_size=32, rx_overrun=1, 33rd byte absent; pulse rx_clear -> rx_size=0, rx_overrun=0.
- Raise cs_n after 5 bits, then a full frame 0xC3 -> RX gets only 0xC3; the next TX byte is aligned to the new frame.
- Assert rstz low mid-frame; master sends 0x5A after reset release -> all outputs at reset values during reset; afterwards RX=0x5A and miso returns 0x00 (TX empty).
